vector_scale_adder: RTL and testbench
=====================================

# vector_scale_adder

Fixed-point vector AXPY engine: computes P[i] = w·X[i] + Y[i] for LENGTH lanes in parallel. It uses one shared signed Q16.16 scale, Q16.16 vector elements and Q32.32 addend/result elements. The block is pipelined and clock-enabled. It sits in the filter datapath wherever a weighted vector update is needed, e.g. sigma-point and mean/covariance accumulation.

## Interface
- `LENGTH`, default 2: number of lanes (≥1).
- `clk`  in  1  rising-edge clock.
- `sclr_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable. The pipeline advances only when `ce`=1.
- `w`  in  32  signed Q16.16 scale factor, shared by all lanes.
- `X`  in  32·LENGTH  packed signed Q16.16 elements; lane i = `X[32i+31:32i]`.
- `Y`  in  64·LENGTH  packed signed Q32.32 addends; lane i = `Y[64i+63:64i]`.
- `P`  out  64·LENGTH  packed signed Q32.32 results; lane i = `P[64i+63:64i]`, registered.

## Operation
- Per lane: the 32×32 signed multiply w·X[i] gives a full-precision 64-bit Q32.32 product. It is exact and never overflows.
- The 64-bit product is added to Y[i] at 64 bits. Default behaviour on overflow: wrap modulo 2^64 (two's complement).
- No rounding or truncation anywhere; the Q32.32 result is exact when there is no overflow.
- All lanes are independent and identical, with no cross-lane interaction.
- `ce`=0: every pipeline register, including `P`, holds its value. Inputs are ignored on that edge.
- `sclr_n`=0: all pipeline registers and `P` clear to 0 immediately, regardless of `clk` and `ce`. Reset dominates `ce`.
- Release of `sclr_n` is synchronized to `clk` by the integrator. The first enabled edge after release samples inputs normally.

## Timing
- Latency is 4 enabled cycles. Inputs sampled on enabled edge E0 appear on `P` after enabled edge E3.
- Stages:
  - S0 registers w, X and Y.
  - S1 multiplies; Y is delayed alongside.
  - S2 adds.
  - S3 is the output register.
- Fully pipelined with throughput 1 vector per enabled cycle. There is no handshake: callers track validity by counting enabled cycles.
- Disabled cycles (`ce`=0) are not counted. A stall freezes in-flight data and resumes it without loss or duplication.
- Reset mid-operation discards all in-flight data. `P` reads 0 until new data has traversed 4 enabled cycles.
- Reset value of `P` is 0.

## Configuration
- `VSAD_SATURATE_EN` defined: the 64-bit add saturates. Positive overflow gives 0x7FFFFFFF_FFFFFFFF; negative overflow gives 0x80000000_00000000.
- `VSAD_SATURATE_EN` undefined: the add wraps modulo 2^64.
- Latency is identical in both cases.

## Structure
- Shared package `vsad_pkg` holds:
  - `WORD_W`=32, `ACC_W`=64, `FRAC_W`=16, `LATENCY`=4;
  - typedefs `word_t` (signed 32) and `acc_t` (signed 64).
- One sub-module, `vsad_lane`: a single-lane registered multiply-add with the same pipeline, `ce` and reset behaviour.
- The top level generates LENGTH instances of `vsad_lane`, slices the packed buses and fans out `w`.

## Test plan
- **Basic, LENGTH=5.**
  - Stimulus: w=0x0000_8000; X lanes 4..0 = ffff_8000, 0, 0019_c000, 0001_0000, 0004_8000; Y lane3 = 0x00000064_80000000, other lanes 0.
  - Required P lanes 4..0: FFFFFFFF_C0000000, 00000064_80000000, 0000000C_E0000000, 00000000_80000000, 00000002_40000000.
- **Basic, LENGTH=2.**
  - Stimulus: w=0x0000_4000; X lanes 1..0 = 0, fff1_8000; Y lane1 = 0x00000004_00000000.
  - Required P lanes 1..0: 00000004_00000000, FFFFFFFC_60000000. `P` changes exactly 4 enabled edges after sampling.
- **Stall.**
  - Stimulus: stream 3 distinct vectors with `ce` low for 2 cycles mid-stream.
  - Required: `P` holds during the stall, and all 3 results appear in order, each after exactly 4 enabled edges.
- **Overflow, one lane.**
  - Stimulus: w=X=0x7FFFFFFF, Y=0x7FFFFFFF_FFFFFFFF.
  - Required: P=0xBFFFFFFF_00000000 without `VSAD_SATURATE_EN`; P=0x7FFFFFFF_FFFFFFFF with it.
- **Reset mid-operation.**
  - Stimulus: assert `sclr_n`=0 asynchronously between edges with data in flight.
  - Required: `P`=0 immediately. After release, old data never appears, and new inputs produce correct results after 4 enabled edges.

Source files
------------

// File: rtl/vsad_pkg.sv
// -----------------------------------------------------------------------------
// vsad_pkg
// Shared widths and types for the vector AXPY engine (vector_scale_adder).
//   WORD_W  : width of the Q16.16 scale and vector elements
//   ACC_W   : width of the Q32.32 addends, products and results
//   FRAC_W  : fractional bits of a Q16.16 word
//   LATENCY : enabled cycles from input sample to result on P
// Optional build macro VSAD_SATURATE_EN (see vsad_lane) uses ACC_MAX/ACC_MIN.
// -----------------------------------------------------------------------------
package vsad_pkg;

    localparam int WORD_W  = 32;
    localparam int ACC_W   = 64;
    localparam int FRAC_W  = 16;
    localparam int LATENCY = 4;

    typedef logic signed [WORD_W-1:0] word_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/vsad_lane.sv
// -----------------------------------------------------------------------------
// vsad_lane
// One lane of the AXPY engine: p = w*x + y, four-stage registered pipeline.
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset, clears every stage
//   ce_i   : clock enable; all stages hold when low
//   w_i    : signed Q16.16 scale
//   x_i    : signed Q16.16 element
//   y_i    : signed Q32.32 addend
//   p_o    : signed Q32.32 result, registered
// Build macro VSAD_SATURATE_EN: saturate the 64-bit add instead of wrapping.
// -----------------------------------------------------------------------------
module vsad_lane
    import vsad_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  ce_i,
    input  word_t w_i,
    input  word_t x_i,
    input  acc_t  y_i,
    output acc_t  p_o
);

    // Two's-complement add; with saturation enabled, an overflow is detected
    // as equal operand signs producing a different result sign.
    function automatic acc_t add_acc(input acc_t a, input acc_t b);
        acc_t s;
        s = a + b;
`ifdef VSAD_SATURATE_EN
        if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
            s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
`endif
        return s;
    endfunction

    word_t w_p0_q;
    word_t x_p0_q;
    acc_t  y_p0_q;
    acc_t  prod_p1_q;
    acc_t  prod_p1_d;
    acc_t  y_p1_q;
    acc_t  sum_p2_q;
    acc_t  sum_p2_d;
    acc_t  p_p3_q;

    // Q16.16 * Q16.16 is an exact Q32.32 in 64 bits; operands are
    // sign-extended first so the product is formed at full width.
    assign prod_p1_d = acc_t'(w_p0_q) * acc_t'(x_p0_q);
    assign sum_p2_d  = add_acc(prod_p1_q, y_p1_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_p0_q    <= '0;
            x_p0_q    <= '0;
            y_p0_q    <= '0;
            prod_p1_q <= '0;
            y_p1_q    <= '0;
            sum_p2_q  <= '0;
            p_p3_q    <= '0;
        end else if (ce_i) begin
            // S0: input capture
            w_p0_q    <= w_i;
            x_p0_q    <= x_i;
            y_p0_q    <= y_i;
            // S1: multiply, addend delayed alongside
            prod_p1_q <= prod_p1_d;
            y_p1_q    <= y_p0_q;
            // S2: add
            sum_p2_q  <= sum_p2_d;
            // S3: output register
            p_p3_q    <= sum_p2_q;
        end
    end

    assign p_o = p_p3_q;

endmodule

// File: rtl/vector_scale_adder.sv
// -----------------------------------------------------------------------------
// vector_scale_adder
// Fixed-point vector AXPY: P[i] = w*X[i] + Y[i] over LENGTH independent lanes,
// latency 4 enabled cycles, one vector per enabled cycle.
//   LENGTH : number of lanes (>= 1)
//   clk    : rising-edge clock
//   sclr_n : asynchronous active-low reset
//   ce     : clock enable
//   w      : signed Q16.16 scale shared by all lanes
//   X      : packed signed Q16.16 elements, lane i = X[32i+31:32i]
//   Y      : packed signed Q32.32 addends, lane i = Y[64i+63:64i]
//   P      : packed signed Q32.32 results, lane i = P[64i+63:64i]
// Build macro VSAD_SATURATE_EN: saturating add (default wraps modulo 2^64).
// -----------------------------------------------------------------------------
module vector_scale_adder
    import vsad_pkg::*;
#(
    parameter int LENGTH = 2
) (
    input  logic                      clk,
    input  logic                      sclr_n,
    input  logic                      ce,
    input  logic [WORD_W-1:0]         w,
    input  logic [WORD_W*LENGTH-1:0]  X,
    input  logic [ACC_W*LENGTH-1:0]   Y,
    output logic [ACC_W*LENGTH-1:0]   P
);

    for (genvar g = 0; g < LENGTH; g++) begin : g_lane
        acc_t p_lane;

        vsad_lane u_lane (
            .clk_i  (clk),
            .rst_ni (sclr_n),
            .ce_i   (ce),
            .w_i    ($signed(w)),
            .x_i    ($signed(X[WORD_W*g +: WORD_W])),
            .y_i    ($signed(Y[ACC_W*g +: ACC_W])),
            .p_o    (p_lane)
        );

        assign P[ACC_W*g +: ACC_W] = p_lane;
    end

endmodule

// File: tb/tb_vector_scale_adder.sv
module tb_vector_scale_adder;

    logic         clk    = 1'b0;
    logic         sclr_n = 1'b1;
    logic         ce     = 1'b0;
    logic [31:0]  w      = '0;
    logic [159:0] X5     = '0;
    logic [319:0] Y5     = '0;
    logic [319:0] P5;
    logic [63:0]  X2     = '0;
    logic [127:0] Y2     = '0;
    logic [127:0] P2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference delay line: entry 0 is what P must show now.
    logic [319:0] m5 [4];
    logic [127:0] m2 [4];

    always #5 clk = ~clk;

    vector_scale_adder #(.LENGTH(5)) dut5 (
        .clk(clk), .sclr_n(sclr_n), .ce(ce), .w(w), .X(X5), .Y(Y5), .P(P5)
    );

    vector_scale_adder #(.LENGTH(2)) dut2 (
        .clk(clk), .sclr_n(sclr_n), .ce(ce), .w(w), .X(X2), .Y(Y2), .P(P2)
    );

    // Exact arithmetic at 66 bits, then wrap or clamp to 64.
    function automatic logic [63:0] axpy(input logic [31:0] ws, input logic [31:0] xs,
                                         input logic [63:0] ys);
        longint             p;
        logic signed [65:0] s;
        p = longint'($signed(ws)) * longint'($signed(xs));
        s = $signed({{2{p[63]}}, p}) + $signed({{2{ys[63]}}, ys});
`ifdef VSAD_SATURATE_EN
        if (s > $signed({2'b00, 64'h7FFF_FFFF_FFFF_FFFF})) s = {2'b00, 64'h7FFF_FFFF_FFFF_FFFF};
        if (s < $signed({2'b11, 64'h8000_0000_0000_0000})) s = {2'b11, 64'h8000_0000_0000_0000};
`endif
        return s[63:0];
    endfunction

    function automatic logic [319:0] vec5(input logic [31:0] ws, input logic [159:0] xv,
                                          input logic [319:0] yv);
        logic [319:0] r;
        for (int i = 0; i < 5; i++) r[64*i +: 64] = axpy(ws, xv[32*i +: 32], yv[64*i +: 64]);
        return r;
    endfunction

    function automatic logic [127:0] vec2(input logic [31:0] ws, input logic [63:0] xv,
                                          input logic [127:0] yv);
        logic [127:0] r;
        for (int i = 0; i < 2; i++) r[64*i +: 64] = axpy(ws, xv[32*i +: 32], yv[64*i +: 64]);
        return r;
    endfunction

    always @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            for (int i = 0; i < 4; i++) begin
                m5[i] <= '0;
                m2[i] <= '0;
            end
        end else if (ce) begin
            m5[0] <= m5[1];
            m5[1] <= m5[2];
            m5[2] <= m5[3];
            m5[3] <= vec5(w, X5, Y5);
            m2[0] <= m2[1];
            m2[1] <= m2[2];
            m2[2] <= m2[3];
            m2[3] <= vec2(w, X2, Y2);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 5; i++)
                chk($sformatf("model_P5_lane%0d", i), P5[64*i +: 64], m5[0][64*i +: 64]);
            for (int i = 0; i < 2; i++)
                chk($sformatf("model_P2_lane%0d", i), P2[64*i +: 64], m2[0][64*i +: 64]);
        end
    end

    task automatic en_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        w  = '0;
        X5 = '0;
        Y5 = '0;
        X2 = '0;
        Y2 = '0;
    endtask

    task automatic rand_inputs();
        case ($urandom_range(0, 3))
            0:       w = 32'h7FFF_FFFF;
            1:       w = 32'h8000_0000;
            default: w = $urandom;
        endcase
        for (int i = 0; i < 5; i++) begin
            X5[32*i +: 32] = $urandom;
            Y5[64*i +: 64] = {$urandom, $urandom};
        end
        for (int i = 0; i < 2; i++) begin
            X2[32*i +: 32] = $urandom;
            Y2[64*i +: 64] = {$urandom, $urandom};
        end
    endtask

    // LENGTH=2 vector: P must stay 0 through E2 and show the result after E3.
    task automatic run_len2_basic(input string tag);
        zero_inputs();
        w  = 32'h0000_4000;
        X2 = {32'h0000_0000, 32'hFFF1_8000};
        Y2 = {64'h00000004_00000000, 64'h0};
        ce = 1'b1;
        en_edge();
        zero_inputs();
        for (int k = 0; k < 2; k++) chk({tag, "_early_lane1"}, P2[127:64], 64'h0);
        en_edge();
        chk({tag, "_early_lane1"}, P2[127:64], 64'h0);
        en_edge();
        chk({tag, "_early_lane1"}, P2[127:64], 64'h0);
        en_edge();
        chk({tag, "_lane1"}, P2[127:64], 64'h00000004_00000000);
        chk({tag, "_lane0"}, P2[63:0],   64'hFFFFFFFC_60000000);
    endtask

    initial begin
        logic [319:0] exp5;

        #1 sclr_n = 1'b0;
        chk_en = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) chk("reset_P5", P5[64*i +: 64], 64'h0);
        for (int i = 0; i < 2; i++) chk("reset_P2", P2[64*i +: 64], 64'h0);
        #20 sclr_n = 1'b1;

        // LENGTH=5 basic vector
        w  = 32'h0000_8000;
        X5 = {32'hFFFF_8000, 32'h0000_0000, 32'h0019_C000, 32'h0001_0000, 32'h0004_8000};
        Y5 = {64'h0, 64'h00000064_80000000, 64'h0, 64'h0, 64'h0};
        ce = 1'b1;
        en_edge();
        zero_inputs();
        repeat (3) en_edge();
        exp5 = {64'hFFFFFFFF_C0000000, 64'h00000064_80000000, 64'h0000000C_E0000000,
                64'h00000000_80000000, 64'h00000002_40000000};
        for (int i = 0; i < 5; i++) chk($sformatf("basic5_lane%0d", i), P5[64*i +: 64], exp5[64*i +: 64]);

        run_len2_basic("basic2");

        // Overflow in one lane
        zero_inputs();
        w  = 32'h7FFF_FFFF;
        X2[31:0] = 32'h7FFF_FFFF;
        Y2[63:0] = 64'h7FFF_FFFF_FFFF_FFFF;
        en_edge();
        zero_inputs();
        repeat (3) en_edge();
`ifdef VSAD_SATURATE_EN
        chk("overflow_lane0", P2[63:0], 64'h7FFF_FFFF_FFFF_FFFF);
`else
        chk("overflow_lane0", P2[63:0], 64'hBFFF_FFFF_0000_0000);
`endif

        // Stall: three vectors, ce low for two cycles mid-stream
        for (int v = 0; v < 3; v++) begin
            rand_inputs();
            en_edge();
            if (v == 1) begin
                ce = 1'b0;
                rand_inputs();
                repeat (2) en_edge();
                ce = 1'b1;
            end
        end
        zero_inputs();
        repeat (5) en_edge();

        // Randomized stream with random ce
        for (int n = 0; n < 300; n++) begin
            ce = ($urandom_range(0, 9) != 0);
            rand_inputs();
            en_edge();
        end

        // Reset with data in flight
        ce = 1'b1;
        repeat (3) begin
            rand_inputs();
            en_edge();
        end
        #2 sclr_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) chk("midreset_P5", P5[64*i +: 64], 64'h0);
        for (int i = 0; i < 2; i++) chk("midreset_P2", P2[64*i +: 64], 64'h0);
        #10 sclr_n = 1'b1;
        run_len2_basic("after_reset");
        for (int n = 0; n < 20; n++) begin
            rand_inputs();
            en_edge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
